// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one valid/ready data-memory port between the core and the io loader.
// Define DMEM_ARB_IO_PRIORITY_EN for fixed io-wins-ties priority; default is round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic lat_we, lat_io, io_win, grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata, rdata;
  assign grant = state == IDLE && (core_req || io_req);
`ifdef DMEM_ARB_IO_PRIORITY_EN
  assign io_win = io_req;
`else
  logic last_io;
  // last_io resets to io so the first tie goes to the core
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) last_io <= 1'b1;
    else if (grant) last_io <= io_win;
  assign io_win = io_req && (!core_req || !last_io);
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (grant ? ISSUE : IDLE) :
               state == ISSUE ? (mem_ready ? (lat_we ? DONE : WAIT) : ISSUE) :
               state == WAIT  ? (mem_rvalid ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      lat_we    <= 1'b0;
      lat_io    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (grant) begin
        lat_io    <= io_win;
        lat_we    <= io_win ? io_we : core_we;
        lat_addr  <= io_win ? io_addr : core_addr;
        lat_wdata <= io_win ? io_wdata : core_wdata;
      end
      if (state == WAIT && mem_rvalid) rdata <= mem_rdata;
    end
  always_comb begin
    mem_valid  = state == ISSUE;
    mem_we     = lat_we;
    mem_addr   = lat_addr;
    mem_wdata  = lat_wdata;
    core_done  = state == DONE && !lat_io;
    io_ack     = state == DONE && lat_io;
    core_rdata = rdata;
    io_rdata   = rdata;
    core_stall = core_req && !core_done;
  end
endmodule
